// File: rtl/disp_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package disp_pkg;

  localparam int         DIGIT_W         = 4;
  localparam logic [7:0] IDLE_DIGITS_DEF = 8'h00;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of (req & ~exclude) at or after rr_ptr.
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  input  logic [NUM_REQ-1:0] exclude,
  output logic               found,
  output logic [NUM_REQ-1:0] pick
);

  logic [NUM_REQ-1:0] masked;
  logic [NUM_REQ-1:0] rot;
  logic [NUM_REQ-1:0] rot_oh;

  // Rotate so rr_ptr sits at bit 0, isolate the lowest set bit, rotate back.
  assign masked = req & ~exclude;
  assign rot    = NUM_REQ'({masked, masked} >> rr_ptr);
  assign rot_oh = rot & (~rot + NUM_REQ'(1));
  assign found  = |rot;
  assign pick   = NUM_REQ'(({rot_oh, rot_oh} << rr_ptr) >> NUM_REQ);

endmodule

// File: rtl/display_arbiter.sv
// Round-robin owner selection for the two-digit display, with a minimum hold
// time counted in slow ticks before another requester may take over.
module display_arbiter
  import disp_pkg::*;
#(
  parameter int         NUM_REQ     = 3,
  parameter int         TICK_PERIOD = 1000000,
  parameter int         HOLD_TICKS  = 50,
  parameter logic [7:0] IDLE_DIGITS = IDLE_DIGITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] data,
  output logic [NUM_REQ-1:0]   grant,
  output logic [DIGIT_W-1:0]   i1,
  output logic [DIGIT_W-1:0]   i2,
  output logic                 busy,
  output logic                 hold_done
);

  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int TICK_W = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

  state_t             state;
  logic [TICK_W-1:0]  tick_cnt;
  logic               tick;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   pick_idx;
  logic [PTR_W-1:0]   next_ptr;
  logic [7:0]         digits;
  logic [7:0]         owner_digits;
  logic [NUM_REQ-1:0] pick;
  logic               found;
  logic               owner_req;
  logic               others_req;

  assign tick = (tick_cnt == TICK_W'(TICK_PERIOD - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tick_cnt <= '0;
    else        tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
  end

  // The current owner is always excluded; when its req is low that changes nothing.
  rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .exclude (grant),
    .found   (found),
    .pick    (pick)
  );

  always_comb begin
    pick_idx     = '0;
    owner_digits = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick[k])  pick_idx     = PTR_W'(k);
      if (grant[k]) owner_digits = data[8*k +: 8];
    end
  end

  assign next_ptr   = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
  assign owner_req  = |(req & grant);
  assign others_req = |(req & ~grant);
  assign busy       = (state == ST_OWN);
  assign hold_done  = (state == ST_OWN) && (hold_cnt == '0);
  assign i1         = digits[3:0];
  assign i2         = digits[7:4];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      grant    <= '0;
      digits   <= IDLE_DIGITS;
      hold_cnt <= '0;
      rr_ptr   <= '0;
    end else if (state == ST_IDLE) begin
      if (found) begin
        state    <= ST_OWN;
        grant    <= pick;
        hold_cnt <= HOLD_W'(HOLD_TICKS);
        rr_ptr   <= next_ptr;
      end
    end else begin
      if (owner_req) digits <= owner_digits;
      // Hand-over only after the hold expires; a lone active owner keeps the display.
      if (hold_done && (!owner_req || others_req)) begin
        if (found) begin
          grant    <= pick;
          hold_cnt <= HOLD_W'(HOLD_TICKS);
          rr_ptr   <= next_ptr;
        end else begin
          state  <= ST_IDLE;
          grant  <= '0;
          digits <= IDLE_DIGITS;
        end
      end else if (tick && !hold_done) begin
        hold_cnt <= hold_cnt - HOLD_W'(1);
      end
    end
  end

endmodule
